// File: rtl/stream_switch_ctrl.sv
// stream_switch_ctrl: packet-level switch controller for AXI-Stream style sources/sinks.
// Each sink owns an independent IDLE/LOCKED controller with a round-robin pointer.
// A sink stays locked to one source until that source's last beat is accepted.
module stream_switch_ctrl #(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic [T_DEST_WIDTH-1:0] s_dest_i [S_DATA_COUNT],
  output logic [S_DATA_COUNT-1:0] s_ready_o,
  input  logic [M_DATA_COUNT-1:0] m_ready_i,
  output logic [M_DATA_COUNT-1:0] m_valid_o,
  output logic [T_ID___WIDTH-1:0] m_sel_o [M_DATA_COUNT],
  output logic [M_DATA_COUNT-1:0] m_lock_o
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]              state_q [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] sel_q   [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] ptr_q   [M_DATA_COUNT];

  logic [S_DATA_COUNT-1:0] req       [M_DATA_COUNT];
  logic [T_ID___WIDTH-1:0] grant_idx [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] grant_vld;
  logic [M_DATA_COUNT-1:0] xfer;

  // Source index that is 'step' positions above 'base', wrapping at S_DATA_COUNT.
  function automatic logic [T_ID___WIDTH-1:0] wrap_idx(input logic [T_ID___WIDTH-1:0] base,
                                                       input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= S_DATA_COUNT) sum = sum - S_DATA_COUNT;
    return T_ID___WIDTH'(sum);
  endfunction

  // Request mask per sink; a destination outside the sink range matches no sink.
  always_comb begin
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      for (int j = 0; j < S_DATA_COUNT; j++) begin
        req[i][j] = s_valid_i[j] && (s_dest_i[j] == T_DEST_WIDTH'(i));
      end
    end
  end

  // Round-robin pick per sink, scanning upward from the source after the last owner.
  always_comb begin
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      grant_vld[i] = 1'b0;
      grant_idx[i] = '0;
      for (int k = 1; k <= S_DATA_COUNT; k++) begin
        if (!grant_vld[i] && req[i][wrap_idx(ptr_q[i], k)]) begin
          grant_vld[i] = 1'b1;
          grant_idx[i] = wrap_idx(ptr_q[i], k);
        end
      end
    end
  end

  // Locked sinks forward the owner's valid and return the sink's ready to that owner.
  always_comb begin
    s_ready_o = '0;
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      m_lock_o[i]  = (state_q[i] == LOCKED);
      m_valid_o[i] = (state_q[i] == LOCKED) && s_valid_i[sel_q[i]];
      xfer[i]      = (state_q[i] == LOCKED) && s_valid_i[sel_q[i]] && m_ready_i[i];
      if ((state_q[i] == LOCKED) && m_ready_i[i]) begin
        s_ready_o[sel_q[i]] = 1'b1;
      end
    end
  end

  assign m_sel_o = sel_q;

  // Per-sink controller: grant from IDLE, release on the accepted last beat.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < M_DATA_COUNT; i++) begin
        state_q[i] <= IDLE;
        sel_q[i]   <= '0;
        ptr_q[i]   <= T_ID___WIDTH'(S_DATA_COUNT - 1);
      end
    end else begin
      for (int i = 0; i < M_DATA_COUNT; i++) begin
        case (state_q[i])
          IDLE: begin
            if (grant_vld[i]) begin
              sel_q[i]   <= grant_idx[i];
              state_q[i] <= LOCKED;
            end
          end
          LOCKED: begin
            if (xfer[i] && s_last_i[sel_q[i]]) begin
              ptr_q[i]   <= sel_q[i];
              state_q[i] <= IDLE;
            end
          end
          default: state_q[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_switch_ctrl.sv
// tb_stream_switch_ctrl: directed scenarios with a per-sink beat scoreboard.
// Packets are queued per source; expected beats are queued per sink in grant order.
module tb_stream_switch_ctrl;

  localparam int S  = 2;
  localparam int M  = 3;
  localparam int IW = 1;
  localparam int DW = 2;

  logic          clk_i;
  logic          rst_in;
  logic [S-1:0]  s_valid_i;
  logic [S-1:0]  s_last_i;
  logic [DW-1:0] s_dest_i [S];
  logic [S-1:0]  s_ready_o;
  logic [M-1:0]  m_ready_i;
  logic [M-1:0]  m_valid_o;
  logic [IW-1:0] m_sel_o [M];
  logic [M-1:0]  m_lock_o;

  int checks   = 0;
  int failures = 0;

  // src_q entries: dest*256 + length; exp_q entries: src*16 + beat index
  int src_q [S][$];
  int exp_q [M][$];
  int beat_idx [S];
  logic [S-1:0] hs;

  stream_switch_ctrl #(
    .S_DATA_COUNT(S),
    .M_DATA_COUNT(M),
    .T_ID___WIDTH(IW),
    .T_DEST_WIDTH(DW)
  ) dut (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .s_valid_i(s_valid_i),
    .s_last_i (s_last_i),
    .s_dest_i (s_dest_i),
    .s_ready_o(s_ready_o),
    .m_ready_i(m_ready_i),
    .m_valid_o(m_valid_o),
    .m_sel_o  (m_sel_o),
    .m_lock_o (m_lock_o)
  );

  // Free-running clock, 10 time units per cycle
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard stop in case a scenario wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present the head packet of each source queue on the source pins
  task automatic drive();
    for (int j = 0; j < S; j++) begin
      if (src_q[j].size() > 0) begin
        s_valid_i[j] = 1'b1;
        s_dest_i[j]  = DW'(src_q[j][0] / 256);
        s_last_i[j]  = (((src_q[j][0] % 256) - beat_idx[j]) == 1);
      end else begin
        s_valid_i[j] = 1'b0;
        s_dest_i[j]  = '0;
        s_last_i[j]  = 1'b0;
      end
    end
  endtask

  // Queue a packet on a source and, for a real sink, its expected beats in grant order
  task automatic applyStimulus(input int src, input int dest, input int len);
    src_q[src].push_back(dest * 256 + len);
    if (dest < M) begin
      for (int b = 0; b < len; b++) exp_q[dest].push_back(src * 16 + b);
    end
    drive();
  endtask

  task automatic flush();
    for (int j = 0; j < S; j++) begin
      src_q[j].delete();
      beat_idx[j] = 0;
    end
    for (int i = 0; i < M; i++) exp_q[i].delete();
    drive();
  endtask

  // One clock: sample handshakes pre-edge, score beats, advance sources after the edge
  task automatic tick();
    int e;
    #1;
    hs = s_valid_i & s_ready_o;
    for (int i = 0; i < M; i++) begin
      if (m_valid_o[i] && m_ready_i[i]) begin
        checkOutput($sformatf("beat_expected_sink%0d", i), 32'(exp_q[i].size() > 0), 32'd1);
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          checkOutput($sformatf("beat_sink%0d", i),
                      32'(int'(m_sel_o[i]) * 16 + beat_idx[m_sel_o[i]]), 32'(e));
        end
      end
    end
    @(posedge clk_i);
    #1;
    for (int j = 0; j < S; j++) begin
      if (hs[j] && src_q[j].size() > 0) begin
        beat_idx[j]++;
        if (beat_idx[j] == (src_q[j][0] % 256)) begin
          void'(src_q[j].pop_front());
          beat_idx[j] = 0;
        end
      end
    end
    drive();
    @(negedge clk_i);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_pending", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
  endtask

  initial begin
    rst_in    = 1'b0;
    m_ready_i = '1;
    for (int j = 0; j < S; j++) beat_idx[j] = 0;
    drive();
    repeat (2) @(negedge clk_i);

    $display("[TB] reset state");
    checkOutput("rst_lock",   32'(m_lock_o),  32'd0);
    checkOutput("rst_valid",  32'(m_valid_o), 32'd0);
    checkOutput("rst_sready", 32'(s_ready_o), 32'd0);
    for (int i = 0; i < M; i++) checkOutput($sformatf("rst_sel%0d", i), 32'(m_sel_o[i]), 32'd0);
    rst_in = 1'b1;

    $display("[TB] round-robin alternation on sink 0");
    applyStimulus(0, 0, 3);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 0, 2);
    #1 checkOutput("rr_lock_before_edge", 32'(m_lock_o[0]), 32'd0);
    tick();
    checkOutput("rr_lock0",   32'(m_lock_o[0]), 32'd1);
    checkOutput("rr_sel0",    32'(m_sel_o[0]),  32'd0);
    checkOutput("rr_sready",  32'(s_ready_o),   32'd1);
    repeat (3) tick();
    checkOutput("rr_bubble",  32'(m_lock_o[0]), 32'd0);
    tick();
    checkOutput("rr_sel_src1", 32'(m_sel_o[0]), 32'd1);
    checkOutput("rr_lock_src1", 32'(m_lock_o[0]), 32'd1);
    repeat (2) tick();
    checkOutput("rr_bubble2", 32'(m_lock_o[0]), 32'd0);
    tick();
    checkOutput("rr_sel_src0_again", 32'(m_sel_o[0]), 32'd0);
    drain(20);

    $display("[TB] backpressure on sink 1");
    m_ready_i[1] = 1'b0;
    applyStimulus(0, 1, 4);
    tick();
    checkOutput("bp_sel1", 32'(m_sel_o[1]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp_lock",   32'(m_lock_o[1]),  32'd1);
      checkOutput("bp_valid",  32'(m_valid_o[1]), 32'd1);
      checkOutput("bp_sready", 32'(s_ready_o[0]), 32'd0);
      checkOutput("bp_held",   32'(exp_q[1].size()), 32'd4);
      tick();
    end
    m_ready_i[1] = 1'b1;
    #1 checkOutput("bp_release_sready", 32'(s_ready_o[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("bp_rate", 32'(exp_q[1].size()), 32'(3 - k));
    end
    checkOutput("bp_unlock", 32'(m_lock_o[1]), 32'd0);

    $display("[TB] parallel sinks");
    applyStimulus(0, 2, 2);
    applyStimulus(1, 1, 3);
    tick();
    checkOutput("par_lock",   32'(m_lock_o),   32'b110);
    checkOutput("par_sel2",   32'(m_sel_o[2]), 32'd0);
    checkOutput("par_sel1",   32'(m_sel_o[1]), 32'd1);
    checkOutput("par_sready", 32'(s_ready_o),  32'b11);
    checkOutput("par_valid",  32'(m_valid_o),  32'b110);
    drain(10);

    $display("[TB] non-preemption on sink 0");
    applyStimulus(1, 0, 4);
    tick();
    checkOutput("np_sel_src1", 32'(m_sel_o[0]), 32'd1);
    tick();
    applyStimulus(0, 0, 2);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("np_sready0_blocked", 32'(s_ready_o[0]), 32'd0);
      checkOutput("np_sel_held",        32'(m_sel_o[0]),   32'd1);
    end
    tick();
    checkOutput("np_bubble_lock",   32'(m_lock_o[0]),  32'd0);
    checkOutput("np_bubble_sready", 32'(s_ready_o[0]), 32'd0);
    tick();
    checkOutput("np_grant_lock",   32'(m_lock_o[0]),  32'd1);
    checkOutput("np_grant_sel",    32'(m_sel_o[0]),   32'd0);
    checkOutput("np_grant_sready", 32'(s_ready_o[0]), 32'd1);
    drain(10);

    $display("[TB] invalid destination");
    applyStimulus(1, 3, 2);
    applyStimulus(0, 2, 2);
    tick();
    checkOutput("inv_lock",   32'(m_lock_o),   32'b100);
    checkOutput("inv_sel2",   32'(m_sel_o[2]), 32'd0);
    checkOutput("inv_sready", 32'(s_ready_o),  32'b01);
    drain(10);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("inv_sready1", 32'(s_ready_o[1]), 32'd0);
      checkOutput("inv_nolock",  32'(m_lock_o),     32'd0);
    end
    flush();

    $display("[TB] reset mid-packet");
    applyStimulus(1, 1, 5);
    tick();
    tick();
    checkOutput("mr_lock_before", 32'(m_lock_o[1]), 32'd1);
    checkOutput("mr_sel_before",  32'(m_sel_o[1]),  32'd1);
    #2 rst_in = 1'b0;
    #1;
    checkOutput("mr_lock",   32'(m_lock_o),   32'd0);
    checkOutput("mr_valid",  32'(m_valid_o),  32'd0);
    checkOutput("mr_sready", 32'(s_ready_o),  32'd0);
    checkOutput("mr_sel1",   32'(m_sel_o[1]), 32'd0);
    flush();
    repeat (2) tick();
    rst_in = 1'b1;
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    tick();
    checkOutput("mr_prio_sel",  32'(m_sel_o[0]),  32'd0);
    checkOutput("mr_prio_lock", 32'(m_lock_o[0]), 32'd1);
    tick();
    checkOutput("single_beat_one_cycle", 32'(m_lock_o[0]), 32'd0);
    tick();
    checkOutput("mr_next_sel", 32'(m_sel_o[0]), 32'd1);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
